// File: rtl/banked_mem_resp.sv
// ---------------------------------------------------------------------------
// banked_mem_resp
//   Single-ported word memory split into four interleaved banks. Each request
//   occupies its bank for three cycles after acceptance. Reads return on a
//   two-stage pipeline, so data appears two cycles after acceptance.
//   Writes commit at the clock edge that ends the accepting cycle.
//
// Optional feature (build macro MEM_REQ_CHECK_EN):
//   defined   : rd&wr together, or an odd byte address, raises err and is
//               dropped without any state change.
//   undefined : err is tied low, addr[0] is ignored, and rd&wr is a write.
//
// Ports
//   clk        in   clock, all state updates on the rising edge
//   rst        in   synchronous active-high reset
//   addr       in   byte address: bank = addr[2:1], word = addr[DEPTH_LOG2:1]
//   data_in    in   write data
//   wr / rd    in   write / read request
//   data_out   out  read data while done=1, zero otherwise
//   done       out  one-cycle pulse marking returned read data
//   stall      out  request present but its bank is busy (requester holds)
//   busy       out  per-bank occupancy, registered
//   err        out  illegal request this cycle
// ---------------------------------------------------------------------------
module banked_mem_resp #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              wr,
  input  logic              rd,
  output logic [DATA_W-1:0] data_out,
  output logic              done,
  output logic              stall,
  output logic [3:0]        busy,
  output logic              err
);

  localparam int WORDS = 1 << DEPTH_LOG2;

  // Per-bank occupancy counter: loads 3 on accept and counts down to idle.
  typedef enum logic [1:0] {
    CNT_IDLE = 2'd0,
    CNT_1    = 2'd1,
    CNT_2    = 2'd2,
    CNT_3    = 2'd3
  } cnt_e;

  logic [DATA_W-1:0]     mem [WORDS];
  cnt_e                  cnt_q [4];
  logic [3:0]            busy_q;
  logic                  rd_v1_q, rd_v2_q;
  logic [DATA_W-1:0]     rd_d1_q, rd_d2_q;

  logic [1:0]            bank;
  logic [DEPTH_LOG2-1:0] widx;
  logic                  req, legal, accept, acc_wr, acc_rd;
  logic [DATA_W-1:0]     rd_word_d;

  assign bank = addr[2:1];
  assign widx = addr[DEPTH_LOG2:1];

  // Address bits above the word index alias; addr[0] is only examined when
  // request checking is built in.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[ADDR_W-1:DEPTH_LOG2+1], addr[0]};

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    req    = rd | wr;
    legal  = 1'b1;
`ifdef MEM_REQ_CHECK_EN
    legal  = !(rd && wr) && !addr[0];
`endif
    err    = 1'b0;
    stall  = 1'b0;
    accept = 1'b0;
    if (!rst && req) begin
      err    = !legal;
      stall  = legal && busy_q[bank];
      accept = legal && !busy_q[bank];
    end
    // A combined rd&wr can only reach here unchecked, where it is a write.
    acc_wr    = accept && wr;
    acc_rd    = accept && rd && !wr;
    rd_word_d = mem[widx];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (rst) begin
        cnt_q[b]  <= CNT_IDLE;
        busy_q[b] <= 1'b0;
      end else begin
        case (cnt_q[b])
          CNT_IDLE: if (accept && bank == b[1:0]) begin
            cnt_q[b]  <= CNT_3;
            busy_q[b] <= 1'b1;
          end
          CNT_3:    cnt_q[b] <= CNT_2;
          CNT_2:    cnt_q[b] <= CNT_1;
          default: begin
            cnt_q[b]  <= CNT_IDLE;
            busy_q[b] <= 1'b0;
          end
        endcase
      end
    end
  end

  // NOTE: the storage array has no reset; contents survive rst and only the
  // control state around it is cleared.
  always_ff @(posedge clk) begin
    if (acc_wr) mem[widx] <= data_in;
  end

  // Two-stage read return. Data registers hold zero whenever their valid bit
  // is low, so data_out needs no gating.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_v1_q <= 1'b0;
      rd_v2_q <= 1'b0;
      rd_d1_q <= '0;
      rd_d2_q <= '0;
    end else begin
      rd_v1_q <= acc_rd;
      rd_d1_q <= acc_rd ? rd_word_d : '0;
      rd_v2_q <= rd_v1_q;
      rd_d2_q <= rd_d1_q;
    end
  end

  assign busy     = busy_q;
  assign done     = rd_v2_q;
  assign data_out = rd_d2_q;

endmodule
